// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, and a backpressure stall counter.
// Optional skid entry (registered in_ready) enabled by defining PIPE_STAGE_REG_SKID_EN.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc8,
  input  logic [4:0]        in_a3,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc8,
  output logic [4:0]        out_a3,
  output logic              out_regwrite,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [31:0]       r_main_pc8;
  logic [4:0]        r_main_a3;
  logic              r_main_rw;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_accept;
  logic              w_pop;

  assign out_valid    = (r_state != S_EMPTY);
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_pop        = out_valid & out_ready;
  assign out_data     = r_main_data;
  assign out_pc8      = r_main_pc8;
  assign out_a3       = r_main_a3;
  assign out_regwrite = r_main_rw & out_valid;
  assign stall_cnt    = r_stall_cnt;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_data;
  logic [31:0]       r_skid_pc8;
  logic [4:0]        r_skid_a3;
  logic              r_skid_rw;

  // in_ready comes straight from a flop; only flush may pull it low combinationally.
  assign in_ready = r_in_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_pc8  <= '0;
      r_main_a3   <= '0;
      r_main_rw   <= 1'b0;
      r_skid_data <= '0;
      r_skid_pc8  <= '0;
      r_skid_a3   <= '0;
      r_skid_rw   <= 1'b0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_pc8  <= in_pc8;
            r_main_a3   <= in_a3;
            r_main_rw   <= in_regwrite;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            r_main_data <= in_data;
            r_main_pc8  <= in_pc8;
            r_main_a3   <= in_a3;
            r_main_rw   <= in_regwrite;
          end else if (w_accept) begin
            r_skid_data <= in_data;
            r_skid_pc8  <= in_pc8;
            r_skid_a3   <= in_a3;
            r_skid_rw   <= in_regwrite;
            r_state     <= S_TWO;
            r_in_ready  <= 1'b0;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_pc8  <= r_skid_pc8;
            r_main_a3   <= r_skid_a3;
            r_main_rw   <= r_skid_rw;
            r_state     <= S_ONE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = (~out_valid | out_ready) & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_pc8  <= '0;
      r_main_a3   <= '0;
      r_main_rw   <= 1'b0;
    end else if (flush) begin
      r_state <= S_EMPTY;
    end else if (w_accept) begin
      // Accept in ONE implies a simultaneous pop, so main is simply reloaded.
      r_main_data <= in_data;
      r_main_pc8  <= in_pc8;
      r_main_a3   <= in_a3;
      r_main_rw   <= in_regwrite;
      r_state     <= S_ONE;
    end else if (w_pop) begin
      r_state <= S_EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of the generic result payload (ALU/load/MD data).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-008 SHALL have ports in_data  input  DATA_W; in_pc8  input  32; in_a3  input  5; in_regwrite  input  1  upstream entry fields.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-011 SHALL have ports out_data  output  DATA_W; out_pc8  output  32; out_a3  output  5; out_regwrite  output  1  head entry fields.
REQ-012 SHALL have port stall_cnt  output  CNT_W  count of backpressured cycles.

Function
REQ-013 SHALL define accept = in_valid & in_ready & !flush, and pop = out_valid & out_ready.
REQ-014 SHALL keep occupancy state EMPTY, ONE (main register full) or TWO (main plus skid register full); out_valid = (state != EMPTY).
REQ-015 SHALL transition EMPTY->ONE on accept, loading main from in_*; latency in-to-out is exactly one cycle.
REQ-016 SHALL, in ONE: accept&pop -> ONE (main <= in_*); accept&!pop -> TWO (skid <= in_*); !accept&pop -> EMPTY; else hold.
REQ-017 SHALL, in TWO: pop -> ONE (main <= skid); else hold; no accept is possible in TWO.
REQ-018 SHALL drive in_ready from a register: 1 in EMPTY/ONE, 0 in TWO; forced 0 while flush=1.
REQ-019 SHALL, on flush=1, go to EMPTY next cycle regardless of accept/pop; flush has priority, and the concurrent input is dropped.
REQ-020 SHALL deliver entries in order, never duplicated or dropped except by flush.
REQ-021 SHALL hold out_data/out_pc8/out_a3 at last value when out_valid=0; out_regwrite SHALL equal stored regwrite & out_valid.
REQ-022 SHALL increment stall_cnt each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-023 SHALL, while reset=0, asynchronously force state EMPTY, main/skid fields 0, stall_cnt 0.
REQ-024 SHALL present during and after reset: out_valid 0, out_data 0, out_pc8 0, out_a3 0, out_regwrite 0, stall_cnt 0, in_ready 1.
REQ-025 SHALL ignore in_valid/out_ready/flush while reset=0; first accept possible on first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with PIPE_STAGE_REG_SKID_EN defined, implement the two-entry skid behaviour of REQ-014..REQ-018.
REQ-027 SHALL, without PIPE_STAGE_REG_SKID_EN, omit the skid register and TWO state; in_ready = (!out_valid | out_ready) & !flush combinationally; ONE with accept&pop reloads main; all other requirements unchanged.

Verification
REQ-028 SHALL cover reset: reset=0 mid-stream with state TWO -> same cycle out_valid 0, out_regwrite 0, stall_cnt 0, in_ready 1.
REQ-029 SHALL cover streaming: out_ready=1, in_data 1..8 on consecutive cycles -> out_data 1..8 each one cycle later, in_ready constantly 1.
REQ-030 SHALL cover skid (macro on): out_ready=0, push 0x11 then 0x22 -> state TWO, in_ready 0, out_data 0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles, stall_cnt = stalled cycle count.
REQ-031 SHALL cover flush: flush=1 in TWO with in_valid=1, in_data 0x33 -> next cycle out_valid 0, out_regwrite 0, in_ready 1; 0x33 never appears.
REQ-032 SHALL cover saturation: CNT_W=4, 20 cycles out_valid=1, out_ready=0 -> stall_cnt 15 and holds.
REQ-033 SHALL cover macro off: out_valid=1, out_ready toggled 1->0 -> in_ready follows 1->0 in the same cycle.
